// File: rtl/permute_pkg.sv
// Shared definitions for the permute-stage sequencer: default geometry,
// round-index width and the controller state encoding.
package permute_pkg;

   localparam int SLICES_DEF = 64;
   localparam int ROUNDS_DEF = 24;
   localparam int ROUND_W    = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/permute_slice_round_cnt.sv
// Nested slice/round counter: the slice index wraps SLICES-1 -> 0 and carries
// into the round index, which wraps ROUNDS-1 -> 0.
module permute_slice_round_cnt
   import permute_pkg::*;
#(
   parameter int SLICES = SLICES_DEF,
   parameter int ROUNDS = ROUNDS_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   output logic [$clog2(SLICES)-1:0] slice,
   output logic [ROUND_W-1:0]        round,
   output logic                       last_slice,
   output logic                       last
);

   localparam int SW = $clog2(SLICES);

   // last flags the final round; combined with last_slice it marks the final read
   assign last_slice = (slice == SW'(SLICES - 1));
   assign last       = (round == ROUND_W'(ROUNDS - 1));

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         slice <= '0;
         round <= '0;
      end else if (en) begin
         if (last_slice) begin
            slice <= '0;
            round <= last ? '0 : round + 1'b1;
         end else begin
            slice <= slice + 1'b1;
         end
      end
   end

endmodule

// File: rtl/permute_ctrl.sv
// Permute-stage sequencer: walks ROUNDS x SLICES reads over the ping-pong slice
// memory, mirrors them one cycle later as writes, and strobes the final round to the dump.
module permute_ctrl
   import permute_pkg::*;
#(
   parameter int SLICES = SLICES_DEF,
   parameter int ROUNDS = ROUNDS_DEF,
   parameter int IDX_W  = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       rd_en,
   output logic [$clog2(SLICES)-1:0] rd_addr,
   output logic                       rd_bank,
   output logic                       wr_en,
   output logic [$clog2(SLICES)-1:0] wr_addr,
   output logic                       wr_bank,
   output logic [ROUND_W-1:0]        round,
   output logic                       write_file,
   output logic [IDX_W-1:0]          file_index,
   output state_e                     fsm_state
);

   localparam int SW = $clog2(SLICES);

   state_e             state;
   state_e             next_state;
   logic               cnt_clr;
   logic               cnt_en;
   logic [SW-1:0]      rd_slice;
   logic [ROUND_W-1:0] rd_round;
   logic               rd_last_slice;
   logic               rd_last_round;
   logic [ROUND_W-1:0] wr_round;

   permute_slice_round_cnt #(
      .SLICES(SLICES),
      .ROUNDS(ROUNDS)
   ) u_rd_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .slice     (rd_slice),
      .round     (rd_round),
      .last_slice(rd_last_slice),
      .last      (rd_last_round)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      rd_en      = 1'b0;
      case (state)
         IDLE: begin
            busy    = 1'b0;
            cnt_clr = 1'b1;
            if (start) next_state = RUN;
         end
         RUN: begin
            rd_en  = 1'b1;
            cnt_en = 1'b1;
            if (rd_last_slice && rd_last_round) next_state = DRAIN;
         end
         DRAIN: next_state = DONE;
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign rd_addr   = rd_slice;
   assign round     = rd_round;
   assign rd_bank   = rd_round[0];
   assign fsm_state = state;

   // One-cycle datapath latency; fields are zeroed when no read is issued so idle outputs stay 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_bank  <= 1'b0;
         wr_round <= '0;
      end else begin
         wr_en    <= rd_en;
         wr_addr  <= rd_en ? rd_slice : '0;
         wr_bank  <= rd_en & ~rd_round[0];
         wr_round <= rd_en ? rd_round : '0;
      end
   end

   assign write_file = wr_en && (wr_round == ROUND_W'(ROUNDS - 1));

   always_ff @(posedge clk) begin
      if (!rst)               file_index <= '0;
      else if (state == DONE) file_index <= file_index + 1'b1;
   end

endmodule

// File: tb/tb_permute_ctrl.sv
// Bench for permute_ctrl: a default-size instance and a reduced (4 slices x 2 rounds)
// instance, both checked every cycle against a run-timeline model.
module tb_permute_ctrl;
   import permute_pkg::*;

   localparam int SA = 64;
   localparam int RA = 24;
   localparam int SB = 4;
   localparam int RB = 2;
   localparam int IW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0, start_a = 1'b0;
   logic rst_b = 1'b0, start_b = 1'b0;

   logic          busy_a, done_a, rd_en_a, rd_bank_a, wr_en_a, wr_bank_a, write_file_a;
   logic [5:0]    rd_addr_a, wr_addr_a;
   logic [4:0]    round_a;
   logic [IW-1:0] file_index_a;
   state_e        fsm_state_a;

   logic          busy_b, done_b, rd_en_b, rd_bank_b, wr_en_b, wr_bank_b, write_file_b;
   logic [1:0]    rd_addr_b, wr_addr_b;
   logic [4:0]    round_b;
   logic [IW-1:0] file_index_b;
   state_e        fsm_state_b;

   permute_ctrl #(.SLICES(SA), .ROUNDS(RA), .IDX_W(IW)) u_dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_bank(rd_bank_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_bank(wr_bank_a),
      .round(round_a), .write_file(write_file_a), .file_index(file_index_a),
      .fsm_state(fsm_state_a)
   );

   permute_ctrl #(.SLICES(SB), .ROUNDS(RB), .IDX_W(IW)) u_dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_bank(rd_bank_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_bank(wr_bank_b),
      .round(round_b), .write_file(write_file_b), .file_index(file_index_b),
      .fsm_state(fsm_state_b)
   );

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          rd_en;
      logic [5:0]    rd_addr;
      logic          rd_bank;
      logic [4:0]    round;
      logic          wr_en;
      logic [5:0]    wr_addr;
      logic          wr_bank;
      logic          write_file;
      logic [IW-1:0] file_index;
   } obs_t;

   int checks = 0;
   int failures = 0;
   int cyc_no = 0;

   // Model: t = cycle number within the current run (0 when idle), f = completed runs
   int t_a = 0, f_a = 0, t_b = 0, f_b = 0;

   always @(posedge clk) begin
      if (!rst_a) begin
         t_a <= 0;
         f_a <= 0;
      end else if (t_a == 0) begin
         if (start_a) t_a <= 1;
      end else if (t_a == SA * RA + 2) begin
         t_a <= 0;
         f_a <= (f_a + 1) % (1 << IW);
      end else begin
         t_a <= t_a + 1;
      end
   end

   always @(posedge clk) begin
      if (!rst_b) begin
         t_b <= 0;
         f_b <= 0;
      end else if (t_b == 0) begin
         if (start_b) t_b <= 1;
      end else if (t_b == SB * RB + 2) begin
         t_b <= 0;
         f_b <= (f_b + 1) % (1 << IW);
      end else begin
         t_b <= t_b + 1;
      end
   end

   function automatic obs_t model_out(input int t, input int s, input int r, input int f);
      obs_t e;
      int   n;
      int   k;
      e = '0;
      n = r * s;
      if (t >= 1 && t <= n) begin
         k         = t - 1;
         e.rd_en   = 1'b1;
         e.rd_addr = 6'(k % s);
         e.round   = 5'(k / s);
         e.rd_bank = 1'((k / s) % 2);
      end
      if (t >= 2 && t <= n + 1) begin
         k            = t - 2;
         e.wr_en      = 1'b1;
         e.wr_addr    = 6'(k % s);
         e.wr_bank    = 1'(((k / s) + 1) % 2);
         e.write_file = ((k / s) == r - 1);
      end
      e.busy       = (t >= 1);
      e.done       = (t == n + 2);
      e.file_index = IW'(f);
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   // Every wait goes through tick so both instances are compared on every cycle
   task automatic tick();
      obs_t act;
      obs_t exp;
      @(negedge clk);
      cyc_no++;
      exp = model_out(t_a, SA, RA, f_a);
      act.busy = busy_a; act.done = done_a; act.rd_en = rd_en_a;
      act.rd_addr = rd_addr_a; act.rd_bank = rd_bank_a; act.round = round_a;
      act.wr_en = wr_en_a; act.wr_addr = wr_addr_a; act.wr_bank = wr_bank_a;
      act.write_file = write_file_a; act.file_index = file_index_a;
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL model_a cycle %0d: got %p, want %p", cyc_no, act, exp);
      end
      exp = model_out(t_b, SB, RB, f_b);
      act.busy = busy_b; act.done = done_b; act.rd_en = rd_en_b;
      act.rd_addr = 6'(rd_addr_b); act.rd_bank = rd_bank_b; act.round = round_b;
      act.wr_en = wr_en_b; act.wr_addr = 6'(wr_addr_b); act.wr_bank = wr_bank_b;
      act.write_file = write_file_b; act.file_index = file_index_b;
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL model_b cycle %0d: got %p, want %p", cyc_no, act, exp);
      end
   endtask

   int         rd_cnt, wr_cnt, wf_cnt;
   logic [5:0] exp_q[$];
   int         bnd_seen, bnd_wa, bnd_wb, bnd_rb;

   task automatic fill_exp_q();
      logic [5:0] a;
      exp_q.delete();
      for (int i = 0; i < SA; i++) begin
         a = 6'(i);
         exp_q.push_back(a);
      end
   endtask

   task automatic wait_done_a(input bit drop, input int want_fidx, output int cyc);
      cyc = 0; rd_cnt = 0; wr_cnt = 0; wf_cnt = 0; bnd_seen = 0;
      while (cyc < 2000) begin
         tick();
         cyc++;
         if (drop) start_a = 1'b0;
         if (rd_en_a) rd_cnt++;
         if (wr_en_a) wr_cnt++;
         if (write_file_a) begin
            wf_cnt++;
            chk("a_wf_fidx", int'(file_index_a), want_fidx);
            if (exp_q.size() > 0) chk("a_wf_addr", int'(wr_addr_a), int'(exp_q.pop_front()));
         end
         if (rd_en_a && round_a == 5'd1 && rd_addr_a == 6'd0) begin
            bnd_seen = 1;
            bnd_wa   = int'(wr_addr_a);
            bnd_wb   = int'(wr_bank_a);
            bnd_rb   = int'(rd_bank_a);
         end
         if (done_a) break;
      end
   endtask

   initial begin
      int cyc;
      int n;

      repeat (3) tick();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (10) tick();
      chk("idle_busy", int'(busy_a), 0);
      chk("idle_done", int'(done_a), 0);
      chk("idle_rd_en", int'(rd_en_a), 0);
      chk("idle_wr_en", int'(wr_en_a), 0);
      chk("idle_write_file", int'(write_file_a), 0);
      chk("idle_file_index", int'(file_index_a), 0);
      chk("idle_state", int'(fsm_state_a), int'(IDLE));
      chk("idle_file_index_b", int'(file_index_b), 0);

      // single permutation
      fill_exp_q();
      start_a = 1'b1;
      wait_done_a(1'b1, 0, cyc);
      chk("single_latency", cyc, 1538);
      chk("single_rd_cnt", rd_cnt, 1536);
      chk("single_wr_cnt", wr_cnt, 1536);
      chk("single_wf_cnt", wf_cnt, 64);
      chk("single_wf_left", exp_q.size(), 0);
      chk("bnd_seen", bnd_seen, 1);
      chk("bnd_wr_addr", bnd_wa, 63);
      chk("bnd_wr_bank", bnd_wb, 1);
      chk("bnd_rd_bank", bnd_rb, 1);
      tick();
      chk("single_fidx_after", int'(file_index_a), 1);
      chk("single_busy_after", int'(busy_a), 0);

      // start held high: back-to-back runs, starts during busy ignored
      rst_a = 1'b0;
      tick();
      rst_a = 1'b1;
      tick();
      chk("hold_fidx0", int'(file_index_a), 0);
      fill_exp_q();
      start_a = 1'b1;
      wait_done_a(1'b0, 0, cyc);
      chk("hold_latency1", cyc, 1538);
      chk("hold_wf_cnt1", wf_cnt, 64);
      tick();
      chk("hold_idle_busy", int'(busy_a), 0);
      chk("hold_fidx1", int'(file_index_a), 1);
      tick();
      chk("hold_restart", int'(busy_a), 1);
      repeat (100) tick();
      start_a = 1'b0;
      fill_exp_q();
      wait_done_a(1'b0, 1, cyc);
      chk("hold_latency2", cyc + 101, 1538);
      chk("hold_wf_cnt2", wf_cnt, 64);
      tick();
      chk("hold_fidx2", int'(file_index_a), 2);
      repeat (3) tick();
      chk("hold_no_queue", int'(busy_a), 0);

      // reset in the middle of a run
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (699) tick();
      rst_a = 1'b0;
      tick();
      chk("mid_rst_busy", int'(busy_a), 0);
      chk("mid_rst_rd_en", int'(rd_en_a), 0);
      chk("mid_rst_wr_en", int'(wr_en_a), 0);
      chk("mid_rst_write_file", int'(write_file_a), 0);
      chk("mid_rst_round", int'(round_a), 0);
      chk("mid_rst_fidx", int'(file_index_a), 0);
      rst_a = 1'b1;
      fill_exp_q();
      start_a = 1'b1;
      wait_done_a(1'b1, 0, cyc);
      chk("post_rst_latency", cyc, 1538);
      chk("post_rst_rd_cnt", rd_cnt, 1536);
      chk("post_rst_wr_cnt", wr_cnt, 1536);
      chk("post_rst_wf_cnt", wf_cnt, 64);
      tick();
      chk("post_rst_fidx", int'(file_index_a), 1);

      // reduced instance: 1024 back-to-back runs wrap file_index
      start_b = 1'b1;
      for (int r = 0; r < 1024; r++) begin
         n = 0;
         while (n < 30 && !done_b) begin
            tick();
            n++;
         end
         chk("b_latency", n, 10);
         tick();
         if (r == 1022) chk("b_fidx_1023", int'(file_index_b), 1023);
         if (r == 1023) chk("b_fidx_wrap", int'(file_index_b), 0);
      end
      start_b = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
